// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the push-button debouncer.
// Contents:
//   state_e                - per-channel qualification state; bit1 equals the debounced level
//   DEFAULT_STABLE_CYCLES  - 10 ms of stable samples at the 50 MHz board clock
//   state_is_busy()        - true while a candidate level change is being qualified
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW  = 2'b00,
    ST_RISE = 2'b01,
    ST_FALL = 2'b10,
    ST_HIGH = 2'b11
  } state_e;

  localparam int unsigned DEFAULT_STABLE_CYCLES = 500000;

  // RISE and FALL are the two encodings whose bits differ.
  function automatic logic state_is_busy(input state_e st);
    return st[1] ^ st[0];
  endfunction

endpackage : btn_debounce_pkg

// File: rtl/btn_debounce_ch.sv
// One debounce channel: two-flop synchroniser, stability counter and qualification FSM.
// Ports:
//   clk     - system clock
//   rst     - asynchronous active-high reset
//   i_pin   - raw button pin, asynchronous to clk
//   o_db    - debounced level (registered)
//   o_busy  - high while a candidate level change is being qualified (registered)
module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_db,
  output logic o_busy
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);

  logic             r_sync1;
  logic             r_s;
  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_db;
  logic             r_busy;
  logic             w_cnt_done;

  // Two-flop synchroniser; only r_s is used downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_s     <= 1'b0;
    end else begin
      r_sync1 <= i_pin;
      r_s     <= r_sync1;
    end
  end

  // Terminal count: this sample completes STABLE_CYCLES consecutive equal samples.
  assign w_cnt_done = (r_cnt == CNT_W'(STABLE_CYCLES - 1));

  // Qualification FSM; outputs are decoded from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_LOW;
      r_cnt   <= '0;
      r_db    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_LOW: begin
          if (r_s) begin
            r_state <= ST_RISE;
            r_cnt   <= CNT_W'(1);
            r_db    <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
            r_db    <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        ST_RISE: begin
          if (!r_s) begin
            // Glitch rejected; next candidate starts from scratch.
            r_state <= ST_LOW;
            r_cnt   <= '0;
            r_db    <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_cnt_done) begin
            r_state <= ST_HIGH;
            r_cnt   <= '0;
            r_db    <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_RISE;
            r_cnt   <= r_cnt + CNT_W'(1);
            r_db    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (!r_s) begin
            r_state <= ST_FALL;
            r_cnt   <= CNT_W'(1);
            r_db    <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_HIGH;
            r_cnt   <= '0;
            r_db    <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        ST_FALL: begin
          if (r_s) begin
            // Release glitch; the button is still considered pressed.
            r_state <= ST_HIGH;
            r_cnt   <= '0;
            r_db    <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_cnt_done) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
            r_db    <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_FALL;
            r_cnt   <= r_cnt + CNT_W'(1);
            r_db    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_LOW;
          r_cnt   <= '0;
          r_db    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_db   = r_db;
  assign o_busy = r_busy;

endmodule : btn_debounce_ch

// File: rtl/btn_debounce.sv
// Multi-channel push-button debouncer for the calculator front panel.
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-high reset
//   btn_in    - raw button pins [N_BTN], asynchronous to clk
//   btn_db    - debounced level per channel (registered)
//   btn_busy  - per-channel qualification-in-progress flag (registered)
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int unsigned N_BTN         = 4,
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_db,
  output logic [N_BTN-1:0] btn_busy
);

  // Channels are fully independent copies.
  for (genvar gi = 0; gi < int'(N_BTN); gi++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .i_pin (btn_in[gi]),
      .o_db  (btn_db[gi]),
      .o_busy(btn_busy[gi])
    );
  end

endmodule : btn_debounce

// File: tb/tb_btn_debounce.sv
// Directed testbench for btn_debounce with STABLE_CYCLES=4, N_BTN=4.
module tb_btn_debounce;

  localparam int unsigned N_BTN         = 4;
  localparam int unsigned STABLE_CYCLES = 4;

  logic             clk;
  logic             rst;
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_db;
  logic [N_BTN-1:0] btn_busy;

  int errors;
  int checks;

  btn_debounce #(
    .N_BTN        (N_BTN),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_in  (btn_in),
    .btn_db  (btn_db),
    .btn_busy(btn_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    btn_in = '0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (btn_db !== 4'b0000 || btn_busy !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async: db=%b busy=%b expected 0000/0000", btn_db, btn_busy);
    end
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      checks++;
      if (btn_db !== 4'b0000 || btn_busy !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle t=%0d: db=%b busy=%b expected 0000/0000", t, btn_db, btn_busy);
      end
    end
  endtask

  // Pin set before edge t=1; busy on edges 3..5, db from edge 6.
  task automatic test_clean_press();
    logic exp_busy;
    logic exp_db;
    btn_in[0] = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      exp_busy = (t >= 3 && t <= 5);
      exp_db   = (t >= 6);
      checks++;
      if (btn_busy[0] !== exp_busy || btn_db[0] !== exp_db) begin
        errors++;
        $display("FAIL clean_press t=%0d: db=%b busy=%b expected db=%b busy=%b",
                 t, btn_db[0], btn_busy[0], exp_db, exp_busy);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pattern;
    logic       exp_db;
    pattern = 4'b0101;
    for (int b = 0; b < 4; b++) begin
      btn_in[1] = pattern[b];
      tick();
      checks++;
      if (btn_db[1] !== 1'b0) begin
        errors++;
        $display("FAIL bounce_phase b=%0d: db=%b expected 0", b, btn_db[1]);
      end
    end
    btn_in[1] = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp_db = (t >= 6);
      checks++;
      if (btn_db[1] !== exp_db) begin
        errors++;
        $display("FAIL bounce_settle t=%0d: db=%b expected %b", t, btn_db[1], exp_db);
      end
    end
  endtask

  task automatic test_release_glitch();
    logic exp_busy;
    btn_in[2] = 1'b1;
    for (int t = 1; t <= 6; t++) tick();
    checks++;
    if (btn_db[2] !== 1'b1) begin
      errors++;
      $display("FAIL glitch_setup: db=%b expected 1", btn_db[2]);
    end
    btn_in[2] = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 2) btn_in[2] = 1'b1;
      exp_busy = (t == 3 || t == 4);
      checks++;
      if (btn_db[2] !== 1'b1 || btn_busy[2] !== exp_busy) begin
        errors++;
        $display("FAIL release_glitch t=%0d: db=%b busy=%b expected db=1 busy=%b",
                 t, btn_db[2], btn_busy[2], exp_busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [N_BTN-1:0] exp_db;
    btn_in[3] = 1'b1;
    for (int t = 1; t <= 3; t++) tick();
    checks++;
    if (btn_busy[3] !== 1'b1 || btn_db !== 4'b0111) begin
      errors++;
      $display("FAIL midq_setup: db=%b busy=%b expected db=0111 busy[3]=1", btn_db, btn_busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (btn_db !== 4'b0000 || btn_busy !== 4'b0000) begin
      errors++;
      $display("FAIL midq_async: db=%b busy=%b expected 0000/0000", btn_db, btn_busy);
    end
    tick();
    @(negedge clk);
    rst = 1'b0;
    // All pins held high: every channel requalifies on edge 6 after release.
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp_db = (t >= 6) ? 4'b1111 : 4'b0000;
      checks++;
      if (btn_db !== exp_db) begin
        errors++;
        $display("FAIL midq_requal t=%0d: db=%b expected %b", t, btn_db, exp_db);
      end
    end
  endtask

  task automatic test_release_all();
    logic [N_BTN-1:0] exp_db;
    btn_in = '0;
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp_db = (t >= 6) ? 4'b0000 : 4'b1111;
      checks++;
      if (btn_db !== exp_db) begin
        errors++;
        $display("FAIL release_all t=%0d: db=%b expected %b", t, btn_db, exp_db);
      end
    end
  endtask

  // Channel i pressed before edge i; its db rises after edge i+5.
  task automatic test_independence();
    logic [N_BTN-1:0] exp_db;
    for (int e = 0; e <= 10; e++) begin
      if (e < 4) btn_in[e] = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) exp_db[i] = (e >= i + 5);
      checks++;
      if (btn_db !== exp_db) begin
        errors++;
        $display("FAIL independence e=%0d: db=%b expected %b", e, btn_db, exp_db);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_reset_mid();
    test_release_all();
    test_independence();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_btn_debounce

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Multi-channel push-button conditioner for the calculator front panel.
- Each raw, asynchronous, bouncing button line is synchronised to clk, then filtered by a per-channel stability counter.
- Produces a clean level per button, which feeds directly into the falling-edge observer stage.
- That stage turns a button release into a single-cycle command pulse.

Parameters:
- N_BTN, 4, number of independent button channels.
- STABLE_CYCLES, 500000, consecutive identical synchronised samples required to accept a new level (10 ms at 50 MHz). Legal range ≥2.
- CNT_W, $clog2(STABLE_CYCLES), counter width. Derived; not to be overridden.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- btn_in  input  N_BTN  raw button pins, asynchronous to clk.
- btn_db  output  N_BTN  debounced level per channel, registered.
- btn_busy  output  N_BTN  high while the channel is qualifying a candidate level change (states RISE or FALL).

Behaviour:
- Reset (async, asserted): all synchroniser flops, counters and states clear immediately. State goes to LOW; btn_db=0; btn_busy=0. Outputs do not wait for a clock edge.
- After reset release, normal operation resumes on the first clk edge.
- Synchroniser: two-flop chain per channel, sync1<=btn_in[i], s<=sync1. The FSM uses only s. No raw pin reaches logic.
- Per-channel FSM (cnt is CNT_W bits):
  - LOW (db=0): s=1 -> RISE, cnt<=1. Otherwise stay, cnt<=0.
  - RISE (db=0, busy=1): s=0 -> LOW, cnt<=0 (glitch rejected). s=1 and cnt==STABLE_CYCLES-1 -> HIGH, cnt<=0. Otherwise cnt<=cnt+1.
  - HIGH (db=1): s=0 -> FALL, cnt<=1. Otherwise stay.
  - FALL (db=1, busy=1): s=1 -> HIGH, cnt<=0. s=0 and cnt==STABLE_CYCLES-1 -> LOW, cnt<=0. Otherwise cnt<=cnt+1.
- btn_db and btn_busy are registered, decoded from next-state. No combinational path from btn_in.
- Latency: if the pin is stable before clk edge k, btn_db changes after edge k+STABLE_CYCLES+1. This requires exactly STABLE_CYCLES consecutive equal samples of s.
- Any single opposite sample during RISE/FALL aborts the qualification. The counter restarts from scratch on the next candidate.
- Counter never wraps: the transition fires at STABLE_CYCLES-1, and cnt is cleared in LOW and HIGH.
- Channels are fully independent. Simultaneous presses on several channels are each qualified on their own.
- Reset mid-qualification: the channel returns to LOW with db=0. A pin still held high then takes a full qualification after release.
- A button held through reset therefore produces one clean 0->1 on btn_db, never a 1->0. The downstream falling-edge stage sees no spurious release.

Decomposition:
- Shared constants header holds:
  - state encodings: ST_LOW=2'b00, ST_RISE=2'b01, ST_FALL=2'b10, ST_HIGH=2'b11 (bit1 = db level);
  - the default STABLE_CYCLES for the 50 MHz board clock.
- Sub-module btn_debounce_ch: synchroniser, counter and FSM for one channel, same clk/rst, parameter STABLE_CYCLES.
- Top instantiates N_BTN copies through a generate loop.

Test Plan (STABLE_CYCLES=4, N_BTN=4):
- Reset then idle: rst=1 async mid-cycle -> btn_db=0, btn_busy=0 immediately. After release with btn_in=0 for 20 cycles -> no change.
- Clean press: btn_in[0] 0->1 before edge 10, held -> btn_busy[0]=1 after edge 12; btn_db[0]=1 after edge 15; busy drops after edge 15.
- Bounce: btn_in[1] toggles 1,0,1,0 every cycle, then held high from edge 20 -> btn_db[1] stays 0 during bounce; rises after edge 25.
- Release glitch: btn_db[2]=1, btn_in[2] low for 2 cycles then high -> btn_db[2] remains 1. The FALL state is entered and aborted.
- Reset mid-qualification: btn_in[3] held high, rst pulsed while btn_busy[3]=1 -> btn_db[3]=0 and busy=0 at once. btn_db[3]=1 exactly STABLE_CYCLES+2 edges after release.
- Independence: all four pins pressed on staggered edges 0,1,2,3 -> each btn_db[i] rises after edge i+5. No cross-channel interaction.
